// File: rtl/mz_kbd_pkg.sv
// Shared types and constants for the MZ-80B PS/2 keyboard path: prefix FSM
// states, PS/2 set-2 control bytes, keymap entry layout and the default keymap.
package mz_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        SKIP
    } kbd_state_t;

    localparam logic [7:0] KB_E0 = 8'hE0;
    localparam logic [7:0] KB_F0 = 8'hF0;
    localparam logic [7:0] KB_E1 = 8'hE1;
    localparam logic [7:0] KB_AA = 8'hAA;
    localparam logic [7:0] KB_FA = 8'hFA;
    localparam logic [7:0] KB_FE = 8'hFE;
    localparam logic [7:0] KB_EE = 8'hEE;

    // Bytes that follow E1 in the Pause/Break make sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } keymap_entry_t;

    function automatic keymap_entry_t km(input int unsigned r, input int unsigned c);
        keymap_entry_t e;
        e.valid = 1'b1;
        e.row   = 4'(r);
        e.col   = 3'(c);
        return e;
    endfunction

    // Index is {ext, scancode}; anything not listed is unmapped.
    function automatic keymap_entry_t default_keymap(input logic [8:0] addr);
        keymap_entry_t e;
        e = '0;
        case (addr)
            9'h105: e = km(0, 7);  9'h075: e = '0;
            9'h175: e = km(0, 0);  9'h172: e = km(0, 1);
            9'h16B: e = km(0, 2);  9'h174: e = km(0, 3);
            9'h16C: e = km(0, 4);  9'h171: e = km(0, 5);
            9'h170: e = km(0, 6);  9'h005: e = km(0, 7);
            9'h05A: e = km(1, 0);  9'h066: e = km(1, 1);
            9'h076: e = km(1, 2);  9'h00D: e = km(1, 3);
            9'h012: e = km(1, 4);  9'h059: e = km(1, 5);
            9'h014: e = km(1, 6);  9'h058: e = km(1, 7);
            9'h03E: e = km(2, 0);  9'h046: e = km(2, 1);
            9'h04C: e = km(2, 2);  9'h052: e = km(2, 3);
            9'h041: e = km(2, 4);  9'h049: e = km(2, 5);
            9'h04A: e = km(2, 6);  9'h029: e = km(2, 7);
            9'h045: e = km(3, 0);  9'h016: e = km(3, 1);
            9'h01E: e = km(3, 2);  9'h026: e = km(3, 3);
            9'h025: e = km(3, 4);  9'h02E: e = km(3, 5);
            9'h036: e = km(3, 6);  9'h03D: e = km(3, 7);
            9'h054: e = km(4, 0);  9'h01C: e = km(4, 1);
            9'h032: e = km(4, 2);  9'h021: e = km(4, 3);
            9'h023: e = km(4, 4);  9'h024: e = km(4, 5);
            9'h02B: e = km(4, 6);  9'h034: e = km(4, 7);
            9'h033: e = km(5, 0);  9'h043: e = km(5, 1);
            9'h03B: e = km(5, 2);  9'h042: e = km(5, 3);
            9'h04B: e = km(5, 4);  9'h03A: e = km(5, 5);
            9'h031: e = km(5, 6);  9'h044: e = km(5, 7);
            9'h04D: e = km(6, 0);  9'h015: e = km(6, 1);
            9'h02D: e = km(6, 2);  9'h01B: e = km(6, 3);
            9'h02C: e = km(6, 4);  9'h03C: e = km(6, 5);
            9'h02A: e = km(6, 6);  9'h01D: e = km(6, 7);
            9'h022: e = km(7, 0);  9'h035: e = km(7, 1);
            9'h01A: e = km(7, 2);  9'h04E: e = km(7, 3);
            9'h055: e = km(7, 4);  9'h05B: e = km(7, 5);
            9'h05D: e = km(7, 6);  9'h00E: e = km(7, 7);
            9'h006: e = km(8, 0);  9'h004: e = km(8, 1);
            9'h00C: e = km(8, 2);  9'h003: e = km(8, 3);
            9'h00B: e = km(8, 4);  9'h083: e = km(8, 5);
            9'h00A: e = km(8, 6);  9'h001: e = km(8, 7);
            9'h070: e = km(9, 0);  9'h069: e = km(9, 1);
            9'h072: e = km(9, 2);  9'h07A: e = km(9, 3);
            9'h06B: e = km(9, 4);  9'h073: e = km(9, 5);
            9'h074: e = km(9, 6);  9'h06C: e = km(9, 7);
            9'h11F: e = km(10, 0); 9'h111: e = km(10, 1);
            9'h011: e = km(10, 2); 9'h114: e = km(10, 3);
            9'h17C: e = km(10, 4); 9'h07C: e = km(10, 5);
            9'h07B: e = km(10, 6); 9'h079: e = km(10, 7);
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mz_kbd_prefix.sv
// PS/2 set-2 prefix decoder: turns the byte stream into one-cycle make/break
// events tagged with the E0 extension bit, and flags overrun bytes.
module mz_kbd_prefix
    import mz_kbd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] kb_data,
    input  logic       kb_valid,
    output logic       ev_valid,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       ev_flush,
    output logic [7:0] ev_code
);

    kbd_state_t state, state_n;
    logic [2:0] skip_cnt, skip_cnt_n;
    logic       is_ctrl;
    logic       is_overrun;

    assign ev_code    = kb_data;
    assign is_ctrl    = (kb_data == KB_AA) || (kb_data == KB_FA) ||
                        (kb_data == KB_FE) || (kb_data == KB_EE);
    assign is_overrun = (kb_data == 8'h00) || (kb_data == 8'hFF);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        ev_valid   = 1'b0;
        ev_break   = 1'b0;
        ev_ext     = 1'b0;
        ev_flush   = 1'b0;
        if (kb_valid) begin
            if (is_overrun) begin
                ev_flush   = 1'b1;
                state_n    = IDLE;
                skip_cnt_n = '0;
            end else if (!is_ctrl) begin
                unique case (state)
                    IDLE: begin
                        if (kb_data == KB_E0) begin
                            state_n = EXT;
                        end else if (kb_data == KB_F0) begin
                            state_n = BRK;
                        end else if (kb_data == KB_E1) begin
                            state_n    = SKIP;
                            skip_cnt_n = PAUSE_SKIP;
                        end else begin
                            ev_valid = 1'b1;
                        end
                    end
                    EXT: begin
                        if (kb_data == KB_F0) begin
                            state_n = EXTBRK;
                        end else begin
                            ev_valid = 1'b1;
                            ev_ext   = 1'b1;
                            state_n  = IDLE;
                        end
                    end
                    BRK: begin
                        ev_valid = 1'b1;
                        ev_break = 1'b1;
                        state_n  = IDLE;
                    end
                    EXTBRK: begin
                        ev_valid = 1'b1;
                        ev_break = 1'b1;
                        ev_ext   = 1'b1;
                        state_n  = IDLE;
                    end
                    SKIP: begin
                        skip_cnt_n = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/mz_keymatrix.sv
// MZ-80B key matrix: PS/2 events -> pressed-key matrix with minimum hold,
// read back as active-low columns. Define MZ_KEYMAP_LOAD_EN for a writable keymap.
module mz_keymatrix
    import mz_kbd_pkg::*;
#(
    parameter int NROWS       = 14,
    parameter int HOLD_CYCLES = 65536,
    parameter int HW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] KB_DATA,
    input  logic       KB_VALID,
    input  logic [4:0] ROW_SEL,
    output logic [7:0] COL_DO,
    output logic       KEY_ANY
`ifdef MZ_KEYMAP_LOAD_EN
    ,
    input  logic       MAP_WE,
    input  logic [8:0] MAP_ADDR,
    input  logic [7:0] MAP_DATA
`endif
);

    localparam logic [4:0]    NROWS_W   = 5'(NROWS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    logic          ev_valid, ev_break, ev_ext, ev_flush;
    logic [7:0]    ev_code;
    keymap_entry_t entry;

    logic [NROWS-1:0][7:0] matrix, matrix_n;
    logic [HW-1:0] hold, hold_n;
    logic          slot_full, slot_full_n;
    logic [3:0]    slot_row, slot_row_n, last_row, last_row_n;
    logic [2:0]    slot_col, slot_col_n, last_col, last_col_n;
    logic          last_valid, last_valid_n;
    logic          key_ok, last_hit, slot_hit;
    logic [7:0]    row_pick, row_or;

    mz_kbd_prefix u_prefix (
        .CLK      (CLK),
        .RST      (RST),
        .kb_data  (KB_DATA),
        .kb_valid (KB_VALID),
        .ev_valid (ev_valid),
        .ev_break (ev_break),
        .ev_ext   (ev_ext),
        .ev_flush (ev_flush),
        .ev_code  (ev_code)
    );

`ifdef MZ_KEYMAP_LOAD_EN
    keymap_entry_t keymap_ram [512];

    // Reset reloads the default table; writes are visible to the next event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < 512; i++)
                keymap_ram[i] <= default_keymap(9'(i));
        end else if (MAP_WE) begin
            keymap_ram[MAP_ADDR] <= keymap_entry_t'(MAP_DATA);
        end
    end

    assign entry = keymap_ram[{ev_ext, ev_code}];
`else
    assign entry = default_keymap({ev_ext, ev_code});
`endif

    assign key_ok   = ev_valid && entry.valid && ({1'b0, entry.row} < NROWS_W);
    assign last_hit = last_valid && (last_row == entry.row) && (last_col == entry.col);
    assign slot_hit = (slot_row == entry.row) && (slot_col == entry.col);

    always_comb begin
        matrix_n     = matrix;
        hold_n       = (hold != '0) ? hold - HW'(1) : hold;
        slot_full_n  = slot_full;
        slot_row_n   = slot_row;
        slot_col_n   = slot_col;
        last_valid_n = last_valid;
        last_row_n   = last_row;
        last_col_n   = last_col;
        if (ev_flush) begin
            matrix_n    = '0;
            slot_full_n = 1'b0;
        end else begin
            if (slot_full && hold == HW'(1)) begin
                matrix_n[slot_row][slot_col] = 1'b0;
                slot_full_n = 1'b0;
            end
            if (key_ok && !ev_break) begin
                matrix_n[entry.row][entry.col] = 1'b1;
                hold_n       = HOLD_LOAD;
                last_valid_n = 1'b1;
                last_row_n   = entry.row;
                last_col_n   = entry.col;
                if (slot_full_n && slot_hit) slot_full_n = 1'b0;
            end else if (key_ok) begin
                // A counter at 1 reaches 0 on this same edge, so treat it as expired.
                if (!last_hit || hold <= HW'(1)) begin
                    matrix_n[entry.row][entry.col] = 1'b0;
                end else begin
                    if (slot_full_n && !slot_hit) matrix_n[slot_row][slot_col] = 1'b0;
                    slot_full_n = 1'b1;
                    slot_row_n  = entry.row;
                    slot_col_n  = entry.col;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            matrix     <= '0;
            hold       <= '0;
            slot_full  <= 1'b0;
            slot_row   <= '0;
            slot_col   <= '0;
            last_valid <= 1'b0;
            last_row   <= '0;
            last_col   <= '0;
        end else begin
            matrix     <= matrix_n;
            hold       <= hold_n;
            slot_full  <= slot_full_n;
            slot_row   <= slot_row_n;
            slot_col   <= slot_col_n;
            last_valid <= last_valid_n;
            last_row   <= last_row_n;
            last_col   <= last_col_n;
        end
    end

    always_comb begin
        row_pick = '0;
        row_or   = '0;
        for (int unsigned r = 0; r < NROWS; r++) begin
            row_or = row_or | matrix[r];
            if (ROW_SEL[3:0] == r[3:0]) row_pick = matrix[r];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            COL_DO  <= 8'hFF;
            KEY_ANY <= 1'b0;
        end else begin
            COL_DO  <= ROW_SEL[4] ? ~row_pick : ~row_or;
            KEY_ANY <= |matrix;
        end
    end

endmodule

// File: tb/tb_mz_keymatrix.sv
// Directed self-checking bench for mz_keymatrix with a shortened hold window.
module tb_mz_keymatrix;

    localparam int HOLD = 64;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] KB_DATA;
    logic       KB_VALID;
    logic [4:0] ROW_SEL;
    logic [7:0] COL_DO;
    logic       KEY_ANY;
`ifdef MZ_KEYMAP_LOAD_EN
    logic       MAP_WE   = 1'b0;
    logic [8:0] MAP_ADDR = '0;
    logic [7:0] MAP_DATA = '0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    mz_keymatrix #(
        .NROWS       (14),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KB_DATA  (KB_DATA),
        .KB_VALID (KB_VALID),
        .ROW_SEL  (ROW_SEL),
        .COL_DO   (COL_DO),
        .KEY_ANY  (KEY_ANY)
`ifdef MZ_KEYMAP_LOAD_EN
        ,
        .MAP_WE   (MAP_WE),
        .MAP_ADDR (MAP_ADDR),
        .MAP_DATA (MAP_DATA)
`endif
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        KB_DATA  = b;
        KB_VALID = 1'b1;
        tick();
        KB_VALID = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        KB_DATA  = '0;
        KB_VALID = 1'b0;
        ROW_SEL  = 5'h14;
        ticks(3);
        check("reset_col", COL_DO, 8'hFF);
        check("reset_any", {7'b0, KEY_ANY}, 8'h00);
        RST = 1'b0;

        // Make and row read
        send(8'h1C);
        tick();
        check("make_row4", COL_DO, 8'hFD);
        check("make_any", {7'b0, KEY_ANY}, 8'h01);
        ROW_SEL = 5'h13; tick();
        check("row3_empty", COL_DO, 8'hFF);
        ROW_SEL = 5'h00; tick();
        check("allrows", COL_DO, 8'hFD);
        ROW_SEL = 5'h1E; tick();
        check("row14_oob", COL_DO, 8'hFF);
        ROW_SEL = 5'h14;
        ticks(HOLD + 4);
        send(8'hF0); send(8'h1C);
        tick();
        check("late_break", COL_DO, 8'hFF);
        check("late_break_any", {7'b0, KEY_ANY}, 8'h00);

        // Extended make/break after a long hold
        ROW_SEL = 5'h10;
        send(8'hE0); send(8'h75);
        tick();
        check("ext_make", COL_DO, 8'hFE);
        ticks(HOLD + 4);
        check("ext_held", COL_DO, 8'hFE);
        send(8'hE0); send(8'hF0); send(8'h75);
        tick();
        check("ext_break", COL_DO, 8'hFF);

        // Short press held until exactly HOLD cycles after make
        ROW_SEL = 5'h14;
        send(8'h1C);
        ticks(9);
        send(8'hF0); send(8'h1C);
        tick();
        check("short_parked", COL_DO, 8'hFD);
        ticks(52);
        check("short_last_held", COL_DO, 8'hFD);
        tick();
        check("short_expired", COL_DO, 8'hFF);

        // Re-make of the parked key cancels the pending release
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        ticks(67);
        check("remake_held", COL_DO, 8'hFD);
        ticks(10);
        send(8'hF0); send(8'h1C);
        tick();
        check("remake_break", COL_DO, 8'hFF);

        // Slot eviction: A not last-made clears at once, B waits for expiry
        send(8'h1C); send(8'h32);
        send(8'hF0);
        check("two_keys", COL_DO, 8'hF9);
        send(8'h1C);
        send(8'hF0);
        check("a_cleared", COL_DO, 8'hFB);
        send(8'h32);
        ticks(60);
        check("b_held", COL_DO, 8'hFB);
        tick();
        check("b_expired", COL_DO, 8'hFF);

        // Pause sequence, unmapped code, control byte inside EXT, overrun
        ROW_SEL = 5'h00;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        tick();
        check("pause_col", COL_DO, 8'hFF);
        check("pause_any", {7'b0, KEY_ANY}, 8'h00);
        send(8'h1C);
        tick();
        check("after_pause_make", COL_DO, 8'hFD);
        send(8'h75);
        tick();
        check("unmapped_drop", COL_DO, 8'hFD);
        ROW_SEL = 5'h10;
        send(8'hE0); send(8'hAA); send(8'h75);
        tick();
        check("aa_in_ext", COL_DO, 8'hFE);
        send(8'h16);
        ROW_SEL = 5'h00;
        tick();
        check("three_keys", COL_DO, 8'hFC);
        send(8'hFF);
        tick();
        check("overrun_col", COL_DO, 8'hFF);
        check("overrun_any", {7'b0, KEY_ANY}, 8'h00);
        ROW_SEL = 5'h14;
        send(8'h1C);
        tick();
        check("post_overrun_make", COL_DO, 8'hFD);
        send(8'h00);
        tick();
        check("zero_flush", COL_DO, 8'hFF);

        // Reset in the middle of an extended break prefix
        send(8'h1C);
        send(8'hE0); send(8'hF0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        check("midreset_col", COL_DO, 8'hFF);
        check("midreset_any", {7'b0, KEY_ANY}, 8'h00);
        send(8'h1C);
        tick();
        check("midreset_make", COL_DO, 8'hFD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
